// File: rtl/boxcar_avg_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | boxcar_avg_filter: running mean over the last 2^LOG2_WIN accepted samples  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module boxcar_avg_filter #(
    parameter int DATA_WIDTH = 14,
    parameter int LOG2_WIN   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_clr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_primed
);

    localparam int ACC_W = DATA_WIDTH + LOG2_WIN;
    localparam int c_N   = 1 << LOG2_WIN;
    localparam logic [LOG2_WIN:0] c_FILL_FULL = (LOG2_WIN + 1)'(c_N);
    localparam logic [LOG2_WIN:0] c_FILL_LAST = (LOG2_WIN + 1)'(c_N - 1);

    logic [DATA_WIDTH-1:0] r_buf [0:c_N-1];
    logic [LOG2_WIN-1:0]   r_wr_ptr;
    logic [LOG2_WIN:0]     r_fill_cnt;
    logic [ACC_W-1:0]      r_acc;

    logic                  w_full;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_oldest;
    logic [ACC_W-1:0]      w_in_ext;
    logic [ACC_W-1:0]      w_old_ext;
    logic [ACC_W-1:0]      w_next_sum;

    assign w_full     = (r_fill_cnt == c_FILL_FULL);
    assign w_accept   = i_rst_n & ~i_clr & i_valid;
    // Until the window has filled, the buffer holds stale words; treat them as zero.
    assign w_oldest   = w_full ? r_buf[r_wr_ptr] : '0;
    assign w_in_ext   = {{LOG2_WIN{i_data[DATA_WIDTH-1]}}, i_data};
    assign w_old_ext  = {{LOG2_WIN{w_oldest[DATA_WIDTH-1]}}, w_oldest};
    assign w_next_sum = r_acc + w_in_ext - w_old_ext;

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_buf[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_acc      <= '0;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_primed   <= 1'b0;
        end else if (i_valid) begin
            r_acc    <= w_next_sum;
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (!w_full) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
            o_primed <= w_full || (r_fill_cnt == c_FILL_LAST);
            // Taking the top DATA_WIDTH bits is an arithmetic shift right by LOG2_WIN.
            o_data   <= w_next_sum[ACC_W-1:LOG2_WIN];
            o_valid  <= 1'b1;
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
